// File: rtl/vid_timing_pkg.sv
// Shared video timing package: default 640x480@60 timing constants and the
// total-period derivation, reused by sync generation and downstream stages.
package vid_timing_pkg;

    localparam int unsigned CNT_W         = 12;
    localparam int unsigned PC_W          = 4;
    localparam int unsigned CNT_MAX_TOTAL = 4096;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Total period of one axis (pixels per line or lines per frame).
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_sync_axis.sv
// One raster axis: wrapping position counter plus registered active/sync
// window flags decoded from the next-state count so they never lag the count.
module vid_sync_axis
    import vid_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned ACTIVE     = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_END   = 752,
    parameter bit          POL        = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             restart_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             de_o,
    output logic             sync_o
);

    localparam int unsigned      LAST_I = TOTAL - 1;
    localparam logic [CNT_W-1:0] LAST   = LAST_I[CNT_W-1:0];
    localparam logic [CNT_W:0]   ACT_L  = ACTIVE[CNT_W:0];
    localparam logic [CNT_W:0]   SS_L   = SYNC_START[CNT_W:0];
    localparam logic [CNT_W:0]   SE_L   = SYNC_END[CNT_W:0];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             de_q, de_d;
    logic             sync_q, sync_d;

    // Next count (restart parks on the last position) and its window decode.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i)
            cnt_d = LAST;
        else if (adv_i)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        de_d   = ({1'b0, cnt_d} < ACT_L);
        sync_d = (({1'b0, cnt_d} >= SS_L) && ({1'b0, cnt_d} < SE_L)) ? POL : ~POL;
    end

    // Count and flags update together, so there is no skew between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= LAST;
            de_q   <= 1'b0;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            de_q   <= de_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign de_o   = de_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vid_sync_gen.sv
// Video sync generator: pixel-phase divider driving horizontal and vertical
// raster axes. Define VID_SYNC_GEN_FRAME_CNT_EN to build the frame_start pulse
// and 16-bit frame counter; otherwise both outputs are constant 0.
module vid_sync_gen
    import vid_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV  = 4,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic [PC_W-1:0]  pc_ena,
    output logic             hde,
    output logic             vde,
    output logic             hs,
    output logic             vs,
    output logic [CNT_W-1:0] raster_x,
    output logic [CNT_W-1:0] raster_y,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
        $error("vid_sync_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("vid_sync_gen: PIX_DIV must be 1..16");
    end

    localparam int unsigned      PC_MAX_I = PIX_DIV - 1;
    localparam logic [PC_W-1:0]  PC_MAX   = PC_MAX_I[PC_W-1:0];
    localparam int unsigned      H_LAST_I = H_TOTAL - 1;
    localparam logic [CNT_W-1:0] H_LAST   = H_LAST_I[CNT_W-1:0];

    logic [PC_W-1:0] pc_q, pc_d;
    logic            tick;
    logic            x_last;

    // Restart wins over a coinciding tick; it also suppresses the advance.
    assign tick   = (pc_q == PC_MAX) && !restart;
    assign x_last = (raster_x == H_LAST);

    // Pixel phase: wraps on the tick, parks on the last phase during restart.
    always_comb begin
        pc_d = pc_q + 1'b1;
        if (restart)
            pc_d = PC_MAX;
        else if (tick)
            pc_d = '0;
    end

    // Pixel phase register; reset parks it so the first clk is a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= PC_MAX;
        else        pc_q <= pc_d;
    end

    assign pc_ena = pc_q;

    vid_sync_axis #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC),
        .POL(HS_POL)
    ) u_haxis (
        .clk(clk), .rst_n(rst_n), .adv_i(tick), .restart_i(restart),
        .cnt_o(raster_x), .de_o(hde), .sync_o(hs)
    );

    vid_sync_axis #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC),
        .POL(VS_POL)
    ) u_vaxis (
        .clk(clk), .rst_n(rst_n), .adv_i(tick && x_last), .restart_i(restart),
        .cnt_o(raster_y), .de_o(vde), .sync_o(vs)
    );

`ifdef VID_SYNC_GEN_FRAME_CNT_EN
    localparam int unsigned      V_LAST_I = V_TOTAL - 1;
    localparam logic [CNT_W-1:0] V_LAST   = V_LAST_I[CNT_W-1:0];

    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Entering (0,0) is the tick that wraps both axes.
    always_comb begin
        frame_start_d = tick && x_last && (raster_y == V_LAST);
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Pulse and counter register alongside the raster state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
`else
    assign frame_start = 1'b0;
    assign frame_cnt   = '0;
`endif

endmodule

// File: tb/tb_vid_sync_gen.sv
// Bench for vid_sync_gen. DUT A: PIX_DIV=4, default timing (line-level checks).
// DUT B: PIX_DIV=1, active-high syncs, small 128x64 raster so whole frames,
// restart and frame counting fit in a short run. Stimulus threads push
// expected values tagged with a cycle number; a monitor pops and compares.
module tb_vid_sync_gen;

    localparam int S_PC = 0, S_X = 1, S_Y = 2, S_HDE = 3, S_VDE = 4,
                   S_HS = 5, S_VS = 6, S_FS = 7, S_FC = 8;

`ifdef VID_SYNC_GEN_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        int          sel;
        int unsigned val;
    } exp_t;

    logic clk;
    logic rst_a_n, restart_a, rst_b_n, restart_b;
    logic [3:0]  pc_a, pc_b;
    logic        hde_a, vde_a, hs_a, vs_a, fs_a;
    logic        hde_b, vde_b, hs_b, vs_b, fs_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    logic [15:0] fc_a, fc_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cyc;
    int          checks;
    int          failures;

    vid_sync_gen #(.PIX_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .restart(restart_a), .pc_ena(pc_a),
        .hde(hde_a), .vde(vde_a), .hs(hs_a), .vs(vs_a),
        .raster_x(x_a), .raster_y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vid_sync_gen #(
        .PIX_DIV(1), .H_ACTIVE(104), .H_FP(8), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(52), .V_FP(4), .V_SYNC(2), .V_BP(6), .HS_POL(1), .VS_POL(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .restart(restart_b), .pc_ena(pc_b),
        .hde(hde_b), .vde(vde_b), .hs(hs_b), .vs(vs_b),
        .raster_x(x_b), .raster_y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 40000) begin
            $display("FAIL watchdog: cyc=%0d required below 40000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    function automatic string sname(input int s);
        case (s)
            S_PC:    return "pc_ena";
            S_X:     return "raster_x";
            S_Y:     return "raster_y";
            S_HDE:   return "hde";
            S_VDE:   return "vde";
            S_HS:    return "hs";
            S_VS:    return "vs";
            S_FS:    return "frame_start";
            default: return "frame_cnt";
        endcase
    endfunction

    function automatic logic [31:0] act(input int d, input int s);
        if (d == 0) begin
            case (s)
                S_PC:    return 32'(pc_a);
                S_X:     return 32'(x_a);
                S_Y:     return 32'(y_a);
                S_HDE:   return 32'(hde_a);
                S_VDE:   return 32'(vde_a);
                S_HS:    return 32'(hs_a);
                S_VS:    return 32'(vs_a);
                S_FS:    return 32'(fs_a);
                default: return 32'(fc_a);
            endcase
        end else begin
            case (s)
                S_PC:    return 32'(pc_b);
                S_X:     return 32'(x_b);
                S_Y:     return 32'(y_b);
                S_HDE:   return 32'(hde_b);
                S_VDE:   return 32'(vde_b);
                S_HS:    return 32'(hs_b);
                S_VS:    return 32'(vs_b);
                S_FS:    return 32'(fs_b);
                default: return 32'(fc_b);
            endcase
        end
    endfunction

    task automatic compare(input int d, input exp_t e);
        logic [31:0] a;
        a = act(d, e.sel);
        checks++;
        if (e.cyc != cyc || a !== 32'(e.val)) begin
            failures++;
            $display("FAIL dut%0d %s cyc=%0d due=%0d: actual=%0d required=%0d",
                     d, sname(e.sel), cyc, e.cyc, a, e.val);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc) compare(0, qa.pop_front());
        while (qb.size() > 0 && qb[0].cyc <= cyc) compare(1, qb.pop_front());
    end

    task automatic push(input int d, input int unsigned c, input int s, input int unsigned v);
        exp_t e;
        e.cyc = c; e.sel = s; e.val = v;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic xy(input int d, input int unsigned c, input int unsigned x, input int unsigned y);
        push(d, c, S_X, x);
        push(d, c, S_Y, y);
    endtask

    task automatic step_to(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic thread_a();
        rst_a_n = 1'b0; restart_a = 1'b0;
        step_to(3);
        xy(0, 3, 799, 524); push(0, 3, S_PC, 3);
        push(0, 3, S_HDE, 0); push(0, 3, S_VDE, 0); push(0, 3, S_HS, 1); push(0, 3, S_VS, 1);
        push(0, 3, S_FS, 0); push(0, 3, S_FC, 0);
        step_to(4);
        rst_a_n = 1'b1;                       // first tick lands on cyc 5
        xy(0, 5, 0, 0); push(0, 5, S_PC, 0);
        push(0, 5, S_HDE, 1); push(0, 5, S_VDE, 1); push(0, 5, S_HS, 1); push(0, 5, S_VS, 1);
        push(0, 5, S_FS, FC_EN ? 1 : 0); push(0, 5, S_FC, FC_EN ? 1 : 0);
        push(0, 6, S_PC, 1); push(0, 6, S_X, 0); push(0, 6, S_FS, 0);
        push(0, 7, S_PC, 2); push(0, 7, S_X, 0);
        push(0, 8, S_PC, 3); push(0, 8, S_X, 0);
        push(0, 9, S_PC, 0); push(0, 9, S_X, 1);
        push(0, 2564, S_X, 639); push(0, 2564, S_HDE, 1);
        push(0, 2565, S_X, 640); push(0, 2565, S_HDE, 0);
        push(0, 2628, S_X, 655); push(0, 2628, S_HS, 1);
        push(0, 2629, S_X, 656); push(0, 2629, S_HS, 0);
        push(0, 3012, S_X, 751); push(0, 3012, S_HS, 0);
        push(0, 3013, S_X, 752); push(0, 3013, S_HS, 1);
        xy(0, 3204, 799, 0);
        xy(0, 3205, 0, 1); push(0, 3205, S_HS, 1);
        push(0, 3354, S_X, 37); push(0, 3354, S_HDE, 1); push(0, 3354, S_HS, 1);
        step_to(3355);
        rst_a_n = 1'b0;                       // mid-line, no clock edge before the check
        push(0, 3355, S_HDE, 0); push(0, 3355, S_VDE, 0); push(0, 3355, S_HS, 1); push(0, 3355, S_VS, 1);
        xy(0, 3355, 799, 524); push(0, 3355, S_PC, 3);
        push(0, 3355, S_FS, 0); push(0, 3355, S_FC, 0);
        step_to(3360);
        rst_a_n = 1'b1;
        xy(0, 3361, 0, 0); push(0, 3361, S_HDE, 1);
        step_to(3363);
    endtask

    task automatic thread_b();
        int unsigned s0;
        rst_b_n = 1'b0; restart_b = 1'b0;
        step_to(3);
        xy(1, 3, 127, 63); push(1, 3, S_PC, 0);
        push(1, 3, S_HDE, 0); push(1, 3, S_VDE, 0); push(1, 3, S_HS, 0); push(1, 3, S_VS, 0);
        push(1, 3, S_FS, 0); push(1, 3, S_FC, 0);
        step_to(4);
        rst_b_n = 1'b1;
        xy(1, 5, 0, 0); push(1, 5, S_PC, 0);
        push(1, 5, S_HDE, 1); push(1, 5, S_VDE, 1); push(1, 5, S_HS, 0); push(1, 5, S_VS, 0);
        push(1, 5, S_FS, FC_EN ? 1 : 0); push(1, 5, S_FC, FC_EN ? 1 : 0);
        push(1, 6, S_X, 1); push(1, 6, S_PC, 0); push(1, 6, S_FS, 0);
        push(1, 7, S_X, 2); push(1, 7, S_PC, 0);
        push(1, 108, S_X, 103); push(1, 108, S_HDE, 1);
        push(1, 109, S_X, 104); push(1, 109, S_HDE, 0);
        push(1, 116, S_X, 111); push(1, 116, S_HS, 0);
        push(1, 117, S_X, 112); push(1, 117, S_HS, 1);
        push(1, 124, S_X, 119); push(1, 124, S_HS, 1);
        push(1, 125, S_X, 120); push(1, 125, S_HS, 0);
        xy(1, 132, 127, 0);
        xy(1, 133, 0, 1);
        xy(1, 6505, 100, 50); push(1, 6505, S_FC, FC_EN ? 1 : 0);
        step_to(6505);
        restart_b = 1'b1;                     // seen at raster (100,50)
        step_to(6506);
        xy(1, 6506, 127, 63); push(1, 6506, S_PC, 0); push(1, 6506, S_FS, 0);
        restart_b = 1'b0;
        s0 = 6507;
        xy(1, s0, 0, 0); push(1, s0, S_PC, 0); push(1, s0, S_HDE, 1);
        push(1, s0, S_FS, FC_EN ? 1 : 0); push(1, s0, S_FC, FC_EN ? 2 : 0);
        for (int unsigned i = 1; i <= 16384; i++) begin
            int unsigned c;
            c = s0 + i;
            case (i)
                6655:  push(1, c, S_VDE, 1);
                6656:  begin push(1, c, S_VDE, 0); push(1, c, S_Y, 52); end
                7167:  push(1, c, S_VS, 0);
                7168:  begin push(1, c, S_VS, 1); push(1, c, S_Y, 56); end
                7169:  push(1, c, S_VS, 1);
                7423:  push(1, c, S_VS, 1);
                7424:  push(1, c, S_VS, 0);
                8191:  xy(1, c, 127, 63);
                8192:  begin xy(1, c, 0, 0); push(1, c, S_FC, FC_EN ? 3 : 0); end
                16383: push(1, c, S_Y, 63);
                16384: begin xy(1, c, 0, 0); push(1, c, S_FC, FC_EN ? 4 : 0); end
                default: ;
            endcase
            push(1, c, S_FS, (FC_EN && (i == 8192 || i == 16384)) ? 1 : 0);
        end
        step_to(s0 + 16386);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fork
            thread_a();
            thread_b();
        join
        repeat (3) @(posedge clk);
        if (qa.size() + qb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", qa.size() + qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vid_sync_gen.md
VID_SYNC_GEN -- requirements
Module: vid_sync_gen

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4, meaning clk cycles per pixel, legal range 1..16.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning vertical timing in lines.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 0, meaning sync active level, 1 = active-high.
REQ-005 Ports SHALL be:
- clk  in  1  pixel master clock
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous frame restart pulse
- pc_ena  out  4  pixel phase counter
- hde  out  1  horizontal display enable
- vde  out  1  vertical display enable
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- raster_x  out  12  current pixel column
- raster_y  out  12  current line
- frame_start  out  1  one-clk pulse at pixel (0,0); optional
- frame_cnt  out  16  frame counter; optional
REQ-006 Design SHALL have one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-007 pc_ena SHALL count 0..PIX_DIV-1 every clk and wrap to 0; with PIX_DIV=1 it SHALL stay 0.
REQ-008 The pixel tick SHALL be the clk where pc_ena==PIX_DIV-1, so that the raster state changes coincide with pc_ena becoming 0 and stay stable for the full pixel period.
REQ-009 On each tick, raster_x SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and raster_y SHALL increment.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-010 raster_y SHALL wrap from V_TOTAL-1 to 0 on the tick where raster_x wraps.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-011 hde, vde, hs and vs SHALL be registered, decoded from next-state counters, and aligned with raster_x/raster_y.
- There SHALL be zero cycles of skew between the raster counters and these flags.
REQ-012 hde SHALL be 1 iff raster_x < H_ACTIVE; vde SHALL be 1 iff raster_y < V_ACTIVE.
REQ-013 hs SHALL be at HS_POL iff H_ACTIVE+H_FP <= raster_x < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL be at ~HS_POL.
REQ-014 vs SHALL be at VS_POL iff V_ACTIVE+V_FP <= raster_y < V_ACTIVE+V_FP+V_SYNC; otherwise it SHALL be at ~VS_POL.
- vs SHALL change only on ticks where raster_x wraps.
REQ-015 restart=1 SHALL force pc_ena to PIX_DIV-1, raster_x to H_TOTAL-1, and raster_y to V_TOTAL-1.
- The next clk SHALL then be a tick to (0,0).
- restart SHALL override a simultaneous tick.
- restart held high SHALL hold this state.
REQ-016 Counter widths SHALL be 12 bits.
- A parameter set with H_TOTAL or V_TOTAL > 4096 SHALL be a compile-time error.

Reset
REQ-017 While rst_n=0, the block SHALL hold:
- pc_ena=PIX_DIV-1, raster_x=H_TOTAL-1, raster_y=V_TOTAL-1;
- hde=0, vde=0, hs=~HS_POL, vs=~VS_POL;
- frame_start=0, frame_cnt=0.
REQ-018 The first clk after rst_n rises SHALL be a tick to (0,0), with hde=1 and vde=1.
REQ-019 Reset asserted mid-frame SHALL return the block to the REQ-017 state immediately, without waiting for a clock edge.

Configuration
REQ-020 With macro VID_SYNC_GEN_FRAME_CNT_EN defined:
- frame_start SHALL pulse 1 for exactly one clk, on the tick entering (0,0), including after reset and after restart.
- frame_cnt SHALL increment on that same clk and wrap from 16'hFFFF to 0.
REQ-021 Without VID_SYNC_GEN_FRAME_CNT_EN:
- frame_start and frame_cnt SHALL be tied to 0;
- no frame counter flops SHALL exist.

Structure
REQ-022 Default timing constants and the H_TOTAL/V_TOTAL derivation SHALL live in shared package vid_timing_pkg, for reuse by downstream OSD and mixer stages.
REQ-023 The block SHALL contain one sub-module, vid_sync_axis, instantiated twice: horizontal and vertical.
- Each instance SHALL be a counter plus active/sync window decode with advance and restart inputs.

Verification
REQ-024 The bench SHALL cover the following scenarios with PIX_DIV=4 and default timing:
- After reset release, pc_ena SHALL read 0,1,2,3,0 and raster_x SHALL read 0 for 4 clks, then 1.
- After reset release, hde falls at raster_x=640, i.e. clk 2560; hs asserts low for raster_x 656..751; 800 pixels per line.
- vde falls at raster_y=480; vs is low for lines 490..491; raster_y wraps 524->0 after 1,680,000 clks.
- Asserting restart at raster (100,50) SHALL give (0,0) on the next clk.
- Asserting restart at raster (100,50) SHALL make frame_start pulse once and frame_cnt go 1->2.
- Asserting rst_n low mid-line SHALL asynchronously give hde=0, vde=0, hs=1, vs=1.
- Building without VID_SYNC_GEN_FRAME_CNT_EN SHALL keep frame_start=0 for 2 full frames.
- With PIX_DIV=1, HS_POL=1, VS_POL=1, the bench SHALL check the tick every clk and active-high sync.
